// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, IDs and error-flag indices for the bus device endpoint
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    localparam int PCKG_SZ = 16;
    typedef logic [PCKG_SZ-1:0] pkt_t;

    // Destination ID lives in the top byte of every packet.
    function automatic logic [ID_W-1:0] dest_id(input pkt_t pkt);
        return pkt[PCKG_SZ-1 -: ID_W];
    endfunction

    localparam int ERR_W        = 3;
    localparam int ERR_TX_OVF   = 0;
    localparam int ERR_POP_UDF  = 1;
    localparam int ERR_MISROUTE = 2;

endpackage

// File: rtl/bus_ep_fifo.sv
// rtl/bus_ep_fifo.sv - first-word-fall-through FIFO with same-cycle write/read rules
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   wr, wdata    write strobe and data; accepted when not full, or when full
//                and a read is accepted in the same cycle
//   rd, rdata    read strobe; rdata shows the head word (0 when empty)
//   count        occupancy 0..depth
//   full, empty  occupancy flags
//   ovf, udf     single-cycle pulses: write dropped / read while empty
module bus_ep_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [width-1:0]         wdata,
    input  logic                     rd,
    output logic [width-1:0]         rdata,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     udf
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             rd_ok;
    logic             wr_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A full FIFO still takes a write when the head leaves in the same cycle;
    // an empty FIFO never serves a read, even if a write lands alongside it.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign ovf   = wr && !wr_ok;
    assign udf   = rd && empty;

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_endpoint.sv
// rtl/bus_dev_endpoint.sv - device-side bus port: TX FIFO to the bus, address-filtered RX FIFO to the host
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tx_wr, tx_data        host writes into the TX FIFO
//   tx_full, tx_count     TX FIFO status
//   pndng, D_pop, pop     TX head presented to the bus, bus pops it
//   push, D_push          bus delivers a word to this port
//   rx_valid, rx_data     RX head presented to the host
//   rx_rd                 host consumes the RX head
//   rx_drop_cnt           saturating count of accepted words lost to a full RX FIFO
//   err_flags             sticky [0] tx overflow, [1] pop underflow, [2] misroute
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              fifo_size = 8,
    parameter logic [ID_W-1:0] dev_id    = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_wr,
    input  logic [pckg_sz-1:0]           tx_data,
    output logic                         tx_full,
    output logic [$clog2(fifo_size):0]   tx_count,
    output logic                         pndng,
    output logic [pckg_sz-1:0]           D_pop,
    input  logic                         pop,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    output logic                         rx_valid,
    output logic [pckg_sz-1:0]           rx_data,
    input  logic                         rx_rd,
    output logic [15:0]                  rx_drop_cnt,
    output logic [ERR_W-1:0]             err_flags
);

    logic                         tx_empty;
    logic                         tx_ovf;
    logic                         tx_udf;

    logic                         rx_full_unused;
    logic                         rx_empty;
    logic [$clog2(fifo_size):0]   rx_count_unused;
    logic                         rx_drop;
    logic                         rx_udf_unused;

    logic [ID_W-1:0]              push_dest;
    logic                         id_match;
    logic                         accept;

    logic [15:0]                  drop_cnt_q;
    logic [ERR_W-1:0]             err_q;

    bus_ep_fifo #(
        .width (pckg_sz),
        .depth (fifo_size)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    assign pndng = !tx_empty;

    // Combinational filter on the delivered word; no extra pipeline stage.
    assign push_dest = D_push[pckg_sz-1 -: ID_W];
    assign id_match  = (push_dest == dev_id) || (push_dest == broadcast);
    assign accept    = push && id_match;

    // An accepted word that the RX FIFO refuses shows up as its ovf pulse.
    bus_ep_fifo #(
        .width (pckg_sz),
        .depth (fifo_size)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (accept),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .count (rx_count_unused),
        .full  (rx_full_unused),
        .empty (rx_empty),
        .ovf   (rx_drop),
        .udf   (rx_udf_unused)
    );

    assign rx_valid = !rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            if (rx_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (tx_ovf) begin
                err_q[ERR_TX_OVF] <= 1'b1;
            end
            if (tx_udf) begin
                err_q[ERR_POP_UDF] <= 1'b1;
            end
            if (push && !id_match) begin
                err_q[ERR_MISROUTE] <= 1'b1;
            end
        end
    end

    assign rx_drop_cnt = drop_cnt_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb/tb_bus_dev_endpoint.sv - directed self-checking bench for bus_dev_endpoint
module tb_bus_dev_endpoint;

    logic        clk;
    logic        reset;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic [3:0]  tx_count;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_rd;
    logic [15:0] rx_drop_cnt;
    logic [2:0]  err_flags;

    int total = 0;
    int bad   = 0;

    bus_dev_endpoint #(
        .pckg_sz   (16),
        .fifo_size (8),
        .dev_id    (8'd2),
        .broadcast (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .tx_count    (tx_count),
        .pndng       (pndng),
        .D_pop       (D_pop),
        .pop         (pop),
        .push        (push),
        .D_push      (D_push),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_rd       (rx_rd),
        .rx_drop_cnt (rx_drop_cnt),
        .err_flags   (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Inputs set before step take effect on the next rising edge; outputs are
    // sampled 1 ns after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tx_wr = 1'b0; tx_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rx_rd = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic tx_write(input logic [15:0] d);
        tx_wr = 1'b1; tx_data = d;
        step();
        tx_wr = 1'b0;
    endtask

    task automatic bus_push(input logic [15:0] d);
        push = 1'b1; D_push = d;
        step();
        push = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // 1. reset state and single word through TX
        check("rst_pndng", pndng, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_D_pop", D_pop, 16'h0000);
        check("rst_rx_data", rx_data, 16'h0000);
        check("rst_drop", rx_drop_cnt, 0);
        check("rst_err", err_flags, 3'b000);

        tx_write(16'h0311);
        check("t1_pndng", pndng, 1);
        check("t1_D_pop", D_pop, 16'h0311);
        pop = 1'b1; step(); pop = 1'b0;
        check("t1_pndng_after_pop", pndng, 0);
        check("t1_err", err_flags, 3'b000);

        // 2. overfill TX, then drain in order
        for (int i = 0; i < 9; i++) begin
            tx_write(16'h0100 + 16'(i));
            if (i == 6) check("t2_not_full_7", tx_full, 0);
            if (i == 7) check("t2_full_8", tx_full, 1);
        end
        check("t2_count", tx_count, 8);
        check("t2_err_ovf", err_flags, 3'b001);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_pop_%0d", i), D_pop, 16'h0100 + 16'(i));
            pop = 1'b1; step(); pop = 1'b0;
        end
        check("t2_empty", pndng, 0);
        check("t2_err_no_udf", err_flags, 3'b001);

        // 3. address filter
        bus_push(16'h02AB);
        bus_push(16'hFFCD);
        bus_push(16'h05EE);
        check("t3_rx_valid", rx_valid, 1);
        check("t3_head0", rx_data, 16'h02AB);
        check("t3_err_misroute", err_flags, 3'b101);
        rx_rd = 1'b1; step(); rx_rd = 1'b0;
        check("t3_head1", rx_data, 16'hFFCD);
        rx_rd = 1'b1; step(); rx_rd = 1'b0;
        check("t3_rx_empty", rx_valid, 0);
        rx_rd = 1'b1; step(); rx_rd = 1'b0;
        check("t3_rd_empty_ignored", err_flags, 3'b101);

        // 4. RX full drops, full + push + rd stores
        for (int i = 0; i < 8; i++) bus_push(16'h0200 + 16'(i));
        check("t4_no_drop_yet", rx_drop_cnt, 0);
        bus_push(16'h0210);
        bus_push(16'h0211);
        check("t4_drop2", rx_drop_cnt, 2);
        push = 1'b1; D_push = 16'h0220; rx_rd = 1'b1;
        step();
        push = 1'b0; rx_rd = 1'b0;
        check("t4_drop_stays", rx_drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_rd_%0d", i), rx_data, (i < 7) ? 16'h0201 + 16'(i) : 16'h0220);
            rx_rd = 1'b1; step(); rx_rd = 1'b0;
        end
        check("t4_rx_drained", rx_valid, 0);

        // 5. pop underflow, empty wr+pop, full wr+pop
        do_reset();
        pop = 1'b1; step(); pop = 1'b0;
        check("t5_udf", err_flags, 3'b010);
        check("t5_udf_count", tx_count, 0);
        check("t5_udf_pndng", pndng, 0);

        do_reset();
        tx_wr = 1'b1; tx_data = 16'h0444; pop = 1'b1;
        step();
        tx_wr = 1'b0; pop = 1'b0;
        check("t5_empty_wrpop_count", tx_count, 1);
        check("t5_empty_wrpop_err", err_flags, 3'b010);
        check("t5_empty_wrpop_head", D_pop, 16'h0444);

        do_reset();
        for (int i = 0; i < 8; i++) tx_write(16'h0300 + 16'(i));
        tx_wr = 1'b1; tx_data = 16'h0399; pop = 1'b1;
        step();
        tx_wr = 1'b0; pop = 1'b0;
        check("t5_full_wrpop_count", tx_count, 8);
        check("t5_full_wrpop_err", err_flags, 3'b000);
        check("t5_full_wrpop_head", D_pop, 16'h0301);
        for (int i = 0; i < 7; i++) begin
            pop = 1'b1; step(); pop = 1'b0;
        end
        check("t5_wrapped_word", D_pop, 16'h0399);

        // 6. reset with both FIFOs holding words, reset beats same-cycle strobes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_write(16'h0500 + 16'(i));
            bus_push(16'h0260 + 16'(i));
        end
        bus_push(16'h0711);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("t6_pre_count", tx_count, 4);
        check("t6_pre_rx_valid", rx_valid, 1);
        check("t6_pre_err", err_flags, 3'b100);
        tx_write(16'h0505);
        check("t6_pre_count5", tx_count, 5);
        reset = 1'b1; tx_wr = 1'b1; tx_data = 16'h0606; push = 1'b1; D_push = 16'h0207;
        pop = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        check("t6_pndng", pndng, 0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_count", tx_count, 0);
        check("t6_err", err_flags, 3'b000);
        check("t6_D_pop", D_pop, 16'h0000);
        check("t6_rx_data", rx_data, 16'h0000);
        check("t6_drop", rx_drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
